// File: rtl/ps2_frame_receiver_pkg.sv
// Shared constants, FSM state encoding and parity helper for the PS/2 frame receiver.
package ps2_frame_receiver_pkg;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);
   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } rx_state_e;

   // PS/2 uses odd parity across the data bits plus the parity bit.
   function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter that only changes level after
// FILTER_LEN consecutive samples at the opposite level.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic iCLK,
   input  logic Reset,
   input  logic line,
   output logic line_filt
);

   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam logic [FLT_W-1:0] CNT_MAX = FLT_W'(FILTER_LEN - 1);

   logic             meta_q, sync_q, filt_q;
   logic [FLT_W-1:0] cnt_q;

   always_ff @(posedge iCLK or posedge Reset) begin
      if (Reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         meta_q <= line;
         sync_q <= meta_q;
         if (sync_q == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            filt_q <= sync_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + FLT_W'(1);
         end
      end
   end

   assign line_filt = filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: filtered clock edge detection, frame FSM with
// timeout, and a small scan-code FIFO with overflow and error reporting.
module ps2_frame_receiver
   import ps2_frame_receiver_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic       iCLK,
   input  logic       Reset,
   input  logic       PS2_KBCLK,
   input  logic       PS2_KBDAT,
   input  logic       read,
   output logic       scan_ready,
   output logic [7:0] scan_code,
   output logic       frame_err,
   output logic       overflow,
   output logic [7:0] err_count
);

   localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_MAX = BIT_CNT_W'(DATA_BITS - 1);

   logic                 kbclk_filt, kbclk_prev_q, fall;
   logic                 dat_meta_q, dat_sync_q;
   rx_state_e            state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 push_q, push_d;
   logic [7:0]           push_data_q, push_data_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overflow_q;
   logic [7:0]           err_count_q;

   logic [7:0]           mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wptr_q, rptr_q;
   logic                 empty, full, pop, wr_en;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .iCLK      (iCLK),
      .Reset     (Reset),
      .line      (PS2_KBCLK),
      .line_filt (kbclk_filt)
   );

   assign fall = kbclk_prev_q & ~kbclk_filt;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      frame_err_d = 1'b0;
      if (state_q == StIdle || fall) tmo_d = '0;
      else                           tmo_d = tmo_q + TMO_W'(1);

      unique case (state_q)
         StIdle: begin
            if (fall && dat_sync_q == START_BIT) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (fall) begin
               shift_d[bit_cnt_q] = dat_sync_q;
               if (bit_cnt_q == BIT_MAX) state_d = StParity;
               else                      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
         end
         StParity: begin
            if (fall) begin
               parity_d = dat_sync_q;
               state_d  = StStop;
            end
         end
         StStop: begin
            if (fall) begin
               if (dat_sync_q == STOP_BIT && parity_ok(shift_q, parity_q)) begin
                  push_d      = 1'b1;
                  push_data_d = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Stalled frame: abandon whatever was collected so far.
      if (state_q != StIdle && !fall && tmo_q == TMO_MAX) begin
         state_d     = StIdle;
         shift_d     = '0;
         tmo_d       = '0;
         frame_err_d = 1'b1;
      end
   end

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
   assign pop   = read & ~empty;
   assign wr_en = push_q & (~full | pop);

   always_ff @(posedge iCLK or posedge Reset) begin
      if (Reset) begin
         kbclk_prev_q <= 1'b1;
         dat_meta_q   <= 1'b1;
         dat_sync_q   <= 1'b1;
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         tmo_q        <= '0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
         err_count_q  <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
      end else begin
         kbclk_prev_q <= kbclk_filt;
         dat_meta_q   <= PS2_KBDAT;
         dat_sync_q   <= dat_meta_q;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         tmo_q        <= tmo_d;
         push_q       <= push_d;
         push_data_q  <= push_data_d;
         frame_err_q  <= frame_err_d;
         if (frame_err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
         if (push_q && full && !pop) overflow_q <= 1'b1;
         if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)   rptr_q <= rptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge iCLK) begin
      if (wr_en) mem[wptr_q[ADDR_W-1:0]] <= push_data_q;
   end

   assign scan_ready = ~empty;
   assign scan_code  = empty ? 8'h00 : mem[rptr_q[ADDR_W-1:0]];
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: bit-level PS/2 stimulus with a
// scoreboard queue of expected scan codes.
module tb_ps2_frame_receiver;
   import ps2_frame_receiver_pkg::*;

   localparam int unsigned FL   = 4;
   localparam int unsigned TMO  = 200;
   localparam int unsigned FD   = 4;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       PS2_KBCLK = 1'b1;
   logic       PS2_KBDAT = 1'b1;
   logic       read = 1'b0;
   logic       scan_ready, frame_err, overflow;
   logic [7:0] scan_code, err_count;

   int         checks = 0;
   int         errors = 0;
   int         err_pulses = 0;
   int         exp_err = 0;
   logic       exp_ovf = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;

   always #5 clk = ~clk;

   ps2_frame_receiver #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (FD)
   ) dut (
      .iCLK       (clk),
      .Reset      (Reset),
      .PS2_KBCLK  (PS2_KBCLK),
      .PS2_KBDAT  (PS2_KBDAT),
      .read       (read),
      .scan_ready (scan_ready),
      .scan_code  (scan_code),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .err_count  (err_count)
   );

   always @(negedge clk) if (frame_err) err_pulses++;

   task automatic ps2_bit(input logic b);
      PS2_KBDAT = b;
      repeat (10) @(negedge clk);
      PS2_KBCLK = 1'b0;
      repeat (20) @(negedge clk);
      PS2_KBCLK = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // Sends a full frame; a good frame is pushed to the scoreboard if the model has room.
   task automatic send_frame(input logic [7:0] b, input logic bad_parity);
      logic p;
      p = ~(^b) ^ bad_parity;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(1'b1);
      PS2_KBDAT = 1'b1;
      if (bad_parity) exp_err++;
      else if (exp_q.size() < FD) exp_q.push_back(b);
      else exp_ovf = 1'b1;
   endtask

   task automatic pulse_read();
      read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL reset_scan_ready got %b want 0", scan_ready); end
      checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code got %h want 00", scan_code); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got %h want 00", err_count); end
   endtask

   task automatic test_single_frame();
      int e0;
      e0 = err_pulses;
      send_frame(8'h1C, 1'b0);
      checks++; if (scan_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", scan_ready); end
      exp_b = exp_q.pop_front();
      checks++; if (scan_code !== exp_b) begin errors++; $display("FAIL single_code got %h want %h", scan_code, exp_b); end
      checks++; if (err_pulses !== e0) begin errors++; $display("FAIL single_no_err got %0d want %0d", err_pulses, e0); end
      pulse_read();
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", scan_ready); end
      checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL single_empty_code got %h want 00", scan_code); end
   endtask

   task automatic test_back_to_back();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      for (int i = 0; i < 2; i++) begin
         exp_b = exp_q.pop_front();
         checks++; if (scan_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, scan_ready); end
         checks++; if (scan_code !== exp_b) begin errors++; $display("FAIL b2b_code%0d got %h want %h", i, scan_code, exp_b); end
         pulse_read();
      end
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", scan_ready); end
      pulse_read();
      checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL b2b_read_empty got %h want 00", scan_code); end
   endtask

   task automatic test_parity_error();
      int e0;
      e0 = err_pulses;
      send_frame(8'h1C, 1'b1);
      checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL parity_pulses got %0d want %0d", err_pulses - e0, 1); end
      checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL parity_err_count got %0d want %0d", err_count, exp_err); end
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL parity_fifo_empty got %b want 0", scan_ready); end
   endtask

   task automatic test_overflow();
      logic [7:0] bytes [5];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
         end
         send_frame(bytes[i], 1'b0);
      end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow, exp_ovf); end
      for (int i = 0; i < 4; i++) begin
         exp_b = exp_q.pop_front();
         checks++; if (scan_code !== exp_b || scan_ready !== 1'b1) begin
            errors++; $display("FAIL ovf_read%0d got %h/%b want %h/1", i, scan_code, scan_ready, exp_b);
         end
         pulse_read();
      end
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", scan_ready); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_pulses;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      checks++; if (dut.state_q === StIdle) begin errors++; $display("FAIL tmo_midframe state %0d want not idle", dut.state_q); end
      repeat (TMO + 20) @(negedge clk);
      exp_err++;
      checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL tmo_pulse got %0d want 1", err_pulses - e0); end
      checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL tmo_state got %0d want idle", dut.state_q); end
      checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL tmo_err_count got %0d want %0d", err_count, exp_err); end
      send_frame(8'h29, 1'b0);
      exp_b = exp_q.pop_front();
      checks++; if (scan_code !== exp_b || scan_ready !== 1'b1) begin
         errors++; $display("FAIL tmo_next_frame got %h/%b want %h/1", scan_code, scan_ready, exp_b);
      end
      pulse_read();
   endtask

   task automatic test_glitch();
      int e0;
      e0 = err_pulses;
      PS2_KBDAT = 1'b0;
      for (int i = 0; i < 5; i++) begin
         PS2_KBCLK = 1'b0;
         repeat (FL - 1) @(negedge clk);
         PS2_KBCLK = 1'b1;
         repeat (6) @(negedge clk);
         checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL glitch_state%0d got %0d want idle", i, dut.state_q); end
      end
      PS2_KBDAT = 1'b1;
      repeat (TMO + 20) @(negedge clk);
      checks++; if (err_pulses !== e0) begin errors++; $display("FAIL glitch_err got %0d want 0", err_pulses - e0); end
      checks++; if (scan_ready !== 1'b0) begin errors++; $display("FAIL glitch_fifo got %b want 0", scan_ready); end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      e0 = err_pulses;
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      exp_err = 0;
      exp_ovf = 1'b0;
      repeat (TMO + 20) @(negedge clk);
      checks++; if (err_pulses !== e0) begin errors++; $display("FAIL rst_mid_pulse got %0d want 0", err_pulses - e0); end
      checks++; if (err_count !== 8'h00 || overflow !== 1'b0) begin
         errors++; $display("FAIL rst_mid_flags got %h/%b want 00/0", err_count, overflow);
      end
      send_frame(8'h5A, 1'b0);
      exp_b = exp_q.pop_front();
      checks++; if (scan_code !== exp_b || scan_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_restart got %h/%b want %h/1", scan_code, scan_ready, exp_b);
      end
      pulse_read();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_parity_error();
      test_overflow();
      test_timeout();
      test_glitch();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed before the filtered PS/2 clock changes level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, iCLK cycles without a PS/2 clock falling edge before an open frame is abandoned (2 ms at 50 MHz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, scan-code buffer entries (power of two).
REQ-004 SHALL have port iCLK  input  1  system clock.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port PS2_KBCLK  input  1  raw PS/2 clock line, asynchronous to iCLK, never driven by this block.
REQ-007 SHALL have port PS2_KBDAT  input  1  raw PS/2 data line, asynchronous to iCLK, never driven by this block.
REQ-008 SHALL have port read  input  1  single-cycle pop request from the consumer.
REQ-009 SHALL have port scan_ready  output  1  FIFO non-empty.
REQ-010 SHALL have port scan_code  output  8  FIFO head entry; 8'h00 when empty.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse per discarded frame (parity, stop or timeout).
REQ-012 SHALL have port overflow  output  1  sticky flag, a valid frame was dropped because the FIFO was full.
REQ-013 SHALL have port err_count  output  8  saturating count of frame_err pulses.

Function
REQ-014 SHALL pass both lines through a 2-flop synchronizer; the synchronized clock SHALL pass through a glitch filter whose output (initially 1) toggles only after FILTER_LEN consecutive samples at the opposite level.
REQ-015 SHALL detect a falling edge as filtered clock 1 -> 0 and sample synchronized data in that same cycle.
REQ-016 SHALL implement states IDLE, DATA, PARITY, STOP, advancing only on falling edges.
REQ-017 IDLE: data 0 -> DATA with bit counter 0; data 1 -> remain IDLE, no error.
REQ-018 DATA: shift data into bit[counter], LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture the parity bit -> STOP.
REQ-020 STOP: if data = 1 and the 8 data bits plus parity contain an odd number of ones, push the byte; otherwise pulse frame_err; always -> IDLE.
REQ-021 SHALL count cycles while not in IDLE, clear the counter on each falling edge, and at TIMEOUT_CYCLES return to IDLE, discard the partial byte and pulse frame_err.
REQ-022 SHALL perform the push in the cycle after the STOP-edge cycle; scan_ready SHALL be high on the following cycle if the FIFO was empty.
REQ-023 read high with FIFO non-empty SHALL pop exactly one entry per cycle; read while empty SHALL be ignored.
REQ-024 Push into a full FIFO SHALL drop the new byte and set overflow; push and pop in the same cycle while full SHALL both succeed with no overflow.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra pointer bit.
REQ-026 err_count SHALL saturate at 8'hFF.

Reset
REQ-027 Reset SHALL force state IDLE, synchronizers and filter to 1, counters 0, FIFO empty, scan_ready 0, scan_code 8'h00, frame_err 0, overflow 0, err_count 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame without a frame_err pulse; reception SHALL restart on the next start bit.

Structure
REQ-029 SHALL place the state encoding and frame constants (11 bits/frame, 8 data bits, start 0, stop 1) in the shared constants package.
REQ-030 SHALL implement the synchronizer and glitch filter as sub-module ps2_line_filter, instantiated once for the clock line.

Verification
REQ-031 Frame 0x1C with parity 0 and stop 1 -> scan_ready high, scan_code 8'h1C, frame_err 0.
REQ-032 Frames F0, 1C back-to-back with no reads -> two entries; successive read pulses return 8'hF0 then 8'h1C, then scan_ready 0.
REQ-033 Frame 0x1C with parity 1 -> frame_err one pulse, err_count 1, FIFO still empty.
REQ-034 Five valid frames with no reads (FIFO_DEPTH 4) -> overflow 1, reads return the first four bytes only.
REQ-035 Start bit plus 3 data bits, then line idle TIMEOUT_CYCLES -> frame_err pulse, state IDLE; next full frame 0x29 is received correctly.
REQ-036 Glitch pulses of FILTER_LEN-1 cycles on PS2_KBCLK during IDLE -> no state change, no error.
